// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        start request, accepted in IDLE or DONE
//   i_dividend     unsigned dividend, sampled on the accepting edge
//   i_divisor      unsigned divisor, sampled on the accepting edge
//   o_quotient     registered quotient, held until the next accepted start
//   o_remainder    registered remainder, held until the next accepted start
//   o_busy         high while iterating
//   o_done         one-cycle pulse when results become valid
//   o_div_by_zero  set with o_done when the divisor was zero, held with results
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_divisor;

    state_t           w_state_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_divisor_nxt;
    logic [WIDTH-1:0] w_quot_nxt;
    logic [WIDTH-1:0] w_remd_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_dz_nxt;

    // One restoring step; an extra top bit keeps the borrow even for divisors >= 2^(WIDTH-1)
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fits;
    logic [WIDTH:0]   w_rem_step;
    logic [WIDTH-1:0] w_q_step;
    logic             w_accept;

    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_trial    = w_shift - {2'b00, r_divisor};
    assign w_fits     = ~w_trial[WIDTH+1];
    assign w_rem_step = w_fits ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    assign w_q_step   = WIDTH'({r_q, w_fits});
    assign w_accept   = i_start && (r_state != S_RUN);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_q_nxt       = r_q;
        w_rem_nxt     = r_rem;
        w_divisor_nxt = r_divisor;
        w_quot_nxt    = o_quotient;
        w_remd_nxt    = o_remainder;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_dz_nxt      = o_div_by_zero;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_divisor_nxt = i_divisor;
                    w_dz_nxt      = 1'b0;
                    if (i_divisor == '0) begin
                        // Divide by zero completes on the accepting edge
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_dz_nxt    = 1'b1;
                        w_quot_nxt  = '1;
                        w_remd_nxt  = i_dividend;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_busy_nxt  = 1'b1;
                        w_q_nxt     = i_dividend;
                        w_rem_nxt   = '0;
                        w_count_nxt = '0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_RUN: begin
                w_q_nxt     = w_q_step;
                w_rem_nxt   = w_rem_step;
                w_count_nxt = r_count + CW'(1);
                if (r_count == CW'(WIDTH - 1)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_quot_nxt  = w_q_step;
                    w_remd_nxt  = w_rem_step[WIDTH-1:0];
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_divisor     <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_q           <= w_q_nxt;
            r_rem         <= w_rem_nxt;
            r_divisor     <= w_divisor_nxt;
            o_quotient    <= w_quot_nxt;
            o_remainder   <= w_remd_nxt;
            o_busy        <= w_busy_nxt;
            o_done        <= w_done_nxt;
            o_div_by_zero <= w_dz_nxt;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=32).
module tb_seq_divider;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             dz;

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done. lat = edges after the accepting edge
    // until done is seen; nbusy = cycles with busy high; ovl = cycles with busy&done;
    // dz_acc = div_by_zero just after the accepting edge.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int nbusy, output int ovl,
                          output logic dz_acc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        dz_acc   = dz;
        lat      = 0;
        nbusy    = 0;
        ovl      = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
        if (busy && done) ovl++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #3;
        total_cnt++;
        if ({quotient, remainder, busy, done, dz} !== '0)
            $display("FAIL reset_outputs: q=%h r=%h busy=%b done=%b dz=%b, required all 0",
                     quotient, remainder, busy, done, dz);
        else pass_cnt++;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat, nbusy, ovl;
        logic dz_acc;
        run_op(32'd100, 32'd7, lat, nbusy, ovl, dz_acc);
        total_cnt++;
        if (lat !== 32) $display("FAIL basic_latency: got %0d required 32", lat);
        else pass_cnt++;
        total_cnt++;
        if (nbusy !== 32) $display("FAIL basic_busy_cycles: got %0d required 32", nbusy);
        else pass_cnt++;
        total_cnt++;
        if (ovl !== 0) $display("FAIL basic_busy_done_overlap: got %0d required 0", ovl);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, dz} !== {32'd14, 32'd2, 1'b0})
            $display("FAIL basic_result: q=%0d r=%0d dz=%b, required q=14 r=2 dz=0",
                     quotient, remainder, dz);
        else pass_cnt++;
        step();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse: done=%b required 0", done);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if ({quotient, remainder, busy, done} !== {32'd14, 32'd2, 1'b0, 1'b0})
            $display("FAIL basic_hold: q=%0d r=%0d busy=%b done=%b, required 14 2 0 0",
                     quotient, remainder, busy, done);
        else pass_cnt++;
    endtask

    task automatic test_wide_divisor();
        int lat, nbusy, ovl;
        logic dz_acc;
        run_op(32'hFFFF_FFFF, 32'h8000_0000, lat, nbusy, ovl, dz_acc);
        total_cnt++;
        if ({quotient, remainder} !== {32'd1, 32'h7FFF_FFFF})
            $display("FAIL wide_ffff_8000: q=%h r=%h, required q=00000001 r=7fffffff",
                     quotient, remainder);
        else pass_cnt++;
        run_op(32'd3, 32'h8000_0001, lat, nbusy, ovl, dz_acc);
        total_cnt++;
        if ({quotient, remainder, lat} !== {32'd0, 32'd3, 32'd32})
            $display("FAIL wide_3_8001: q=%h r=%h lat=%0d, required q=0 r=3 lat=32",
                     quotient, remainder, lat);
        else pass_cnt++;
        step();
    endtask

    task automatic test_div_zero();
        int lat, nbusy, ovl;
        logic dz_acc;
        run_op(32'd5, 32'd0, lat, nbusy, ovl, dz_acc);
        total_cnt++;
        if ({lat, nbusy} !== {32'd0, 32'd0})
            $display("FAIL dz_timing: edges_after_accept=%0d busy_cycles=%0d, required 0 0",
                     lat, nbusy);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, dz, busy} !== {32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0})
            $display("FAIL dz_result: q=%h r=%0d dz=%b busy=%b, required ffffffff 5 1 0",
                     quotient, remainder, dz, busy);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({done, dz} !== 2'b01)
            $display("FAIL dz_hold: done=%b dz=%b, required done=0 dz=1", done, dz);
        else pass_cnt++;
        run_op(32'd9, 32'd3, lat, nbusy, ovl, dz_acc);
        total_cnt++;
        if (dz_acc !== 1'b0) $display("FAIL dz_clear_on_accept: dz=%b required 0", dz_acc);
        else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, dz} !== {32'd3, 32'd0, 1'b0})
            $display("FAIL dz_followup: q=%0d r=%0d dz=%b, required 3 0 0",
                     quotient, remainder, dz);
        else pass_cnt++;
        step();
    endtask

    task automatic test_start_ignored();
        int first_done, ndone;
        logic [WIDTH-1:0] q_seen, r_seen;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd33;
        step();
        first_done = 0;
        ndone = 0;
        q_seen = '0;
        r_seen = '0;
        for (int c = 1; c <= 40; c++) begin
            start    = (c == 10);
            dividend = (c == 10) ? 32'd50 : 32'd0;
            divisor  = (c == 10) ? 32'd5 : 32'd0;
            step();
            if (done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = c;
                    q_seen = quotient;
                    r_seen = remainder;
                end
            end
        end
        start = 1'b0;
        total_cnt++;
        if ({first_done, ndone} !== {32'd32, 32'd1})
            $display("FAIL ignore_done: first_done_edge=%0d done_count=%0d, required 32 1",
                     first_done, ndone);
        else pass_cnt++;
        total_cnt++;
        if ({q_seen, r_seen} !== {32'd30, 32'd10})
            $display("FAIL ignore_result: q=%0d r=%0d, required q=30 r=10", q_seen, r_seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, nbusy, ovl;
        logic dz_acc;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd33;
        step();
        start = 1'b0;
        for (int c = 0; c < 10; c++) step();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy: busy=%b required 1", busy);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({quotient, remainder, busy, done, dz} !== '0)
            $display("FAIL rst_mid_outputs: q=%h r=%h busy=%b done=%b dz=%b, required all 0",
                     quotient, remainder, busy, done, dz);
        else pass_cnt++;
        step();
        rst = 1'b0;
        step();
        run_op(32'd20, 32'd6, lat, nbusy, ovl, dz_acc);
        total_cnt++;
        if ({quotient, remainder, lat, nbusy} !== {32'd3, 32'd2, 32'd32, 32'd32})
            $display("FAIL rst_mid_after: q=%0d r=%0d lat=%0d busy_cycles=%0d, required 3 2 32 32",
                     quotient, remainder, lat, nbusy);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd2;
        step();
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        total_cnt++;
        if ({quotient, remainder, lat} !== {32'd3, 32'd1, 32'd32})
            $display("FAIL b2b_first: q=%0d r=%0d lat=%0d, required 3 1 32",
                     quotient, remainder, lat);
        else pass_cnt++;
        dividend = 32'hFFFF_FFFF;
        divisor  = 32'd1;
        step();
        start = 1'b0;
        total_cnt++;
        if ({busy, done} !== 2'b10)
            $display("FAIL b2b_no_gap: busy=%b done=%b, required busy=1 done=0", busy, done);
        else pass_cnt++;
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        total_cnt++;
        if ({quotient, remainder, lat} !== {32'hFFFF_FFFF, 32'd0, 32'd32})
            $display("FAIL b2b_second: q=%h r=%h lat=%0d, required ffffffff 0 32",
                     quotient, remainder, lat);
        else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide_divisor();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned integer divider: the subtractive counterpart of the combinational carry-lookahead adders in the ALU datapath. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder via restoring shift-subtract, one quotient bit per clock. It sits beside the ALU and is used for divide/modulo instructions. The control unit stalls on `busy` and captures results on `done`.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.

- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled on the rising edge, accepted only in IDLE or DONE.
- `dividend`  input  WIDTH  unsigned dividend; sampled on the accepting edge only.
- `divisor`  input  WIDTH  unsigned divisor; sampled on the accepting edge only.
- `quotient`  output  WIDTH  result quotient; registered.
- `remainder`  output  WIDTH  result remainder; registered.
- `busy`  output  1  high while an operation is iterating (RUN).
- `done`  output  1  single-cycle pulse; results valid while high and held afterwards.
- `div_by_zero`  output  1  set with `done` when divisor was 0; held with results.

## Operation
- States: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE or DONE with `start`=1:
  - Latch operands.
  - Clear `div_by_zero`.
  - If divisor is 0, go to DONE directly.
  - Otherwise load the working quotient register with the dividend, clear the partial remainder, clear the iteration counter, and go to RUN.
- IDLE or DONE with `start`=0: DONE returns to IDLE. Outputs are unchanged.
- RUN, one iteration per clock, WIDTH iterations total:
  - Shift the partial remainder left by one, bringing in the quotient-register MSB.
  - Compute trial = shifted remainder − divisor.
  - If trial is non-negative, remainder ← trial and shift in quotient bit 1. Otherwise keep the shifted remainder and shift in 0.
  - Increment the counter. After the WIDTH-th iteration, go to DONE.
- The partial remainder and trial are WIDTH+1 bits wide. The shifted value can reach 2·divisor−1, so a borrow must not be lost when divisor ≥ 2^(WIDTH−1).
- DONE:
  - `done`=1 for exactly one cycle.
  - `quotient` and `remainder` are updated on the edge entering DONE and held until the next accepted start.
  - On the entry edge, `div_by_zero` is set if the divisor was 0 and cleared otherwise. It then holds until the next accepted start.
- Divide by zero: `quotient` = all ones, `remainder` = dividend, `div_by_zero`=1.
- `start` during RUN is ignored. No queuing, and the operation in flight is unaffected.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset (asynchronous, any time, including mid-RUN): state IDLE, counter 0, `quotient`=0, `remainder`=0, `busy`=0, `done`=0, `div_by_zero`=0. The operation in flight is discarded.
- Normal op, start accepted at edge k:
  - `busy`=1 from after edge k until after edge k+WIDTH.
  - `done`=1 in the cycle after edge k+WIDTH, with results valid.
  - Latency: WIDTH cycles.
- Divide by zero accepted at edge k: `busy` stays 0, and `done`=1 in the cycle after edge k. Latency: 1 cycle.
- `busy` and `done` are never high together.
- Back-to-back: `start` high while `done`=1 is accepted on that edge. `done` drops, and `busy` rises (or `done` re-pulses for divide by zero). Zero dead cycles between operations.
- The edge after `done` with no start returns to IDLE. Results stay held.

## Test plan
- 100 / 7 (WIDTH=32) → `busy` for 32 cycles; `done` at cycle 32 with q=14, r=2, dz=0. Then release `start` and confirm results hold.
- 0xFFFFFFFF / 0x80000000 → q=1, r=0x7FFFFFFF. Also 3 / 0x80000001 → q=0, r=3, exercising the WIDTH+1 remainder.
- 5 / 0 → `done` one cycle after the accepting edge, q=0xFFFFFFFF, r=5, dz=1, `busy` never high. Follow with 9 / 3 → dz cleared on acceptance, q=3, r=0.
- Pulse `start` with 50 / 5 at RUN cycle 10 of 1000 / 33 → ignored. Result q=30, r=10 at cycle 32, with no second `done`.
- Assert `rst` asynchronously mid-edge at RUN cycle 10 → all outputs 0 immediately. After release, 20 / 6 gives q=3, r=2 with full 32-cycle latency.
- Back-to-back: hold `start` high with 7 / 2, then 0xFFFFFFFF / 1 on the `done` cycle → q=3, r=1, then 32 cycles later q=0xFFFFFFFF, r=0. No idle cycle between operations.
